// File: rtl/twop_rf_pkg.sv
// Shared types and helpers for the two-port register file.
//   ram_ctrl_t : macro timing trim fields (RTSEL/WTSEL/MTSEL plus one spare bit)
//   be_merge   : replaces the bytes selected by `be` in `old_w` with bytes of `new_w`
// The merge helper works at a fixed maximum width. Callers zero-extend their
// operands and truncate the result, so any DW up to MAX_DW can use it.
package twop_rf_pkg;

  localparam int MAX_DW = 1024;
  localparam int MAX_BE = MAX_DW / 8;

  // Bit layout matches the 7-bit ram_ctrl port: [1:0] rtsel, [3:2] wtsel, [5:4] mtsel, [6] spare.
  typedef struct packed {
    logic       spare;
    logic [1:0] mtsel;
    logic [1:0] wtsel;
    logic [1:0] rtsel;
  } ram_ctrl_t;

  function automatic logic [MAX_DW-1:0] be_merge(input logic [MAX_DW-1:0] old_w,
                                                 input logic [MAX_DW-1:0] new_w,
                                                 input logic [MAX_BE-1:0] be);
    logic [MAX_DW-1:0] res;
    res = old_w;
    for (int k = 0; k < MAX_BE; k++) begin
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/twop_rf_array.sv
// Storage for the two-port register file: byte-masked write, registered read.
// A read and a write to the same word in the same cycle return the OLD word
// (read-before-write); any forwarding is the parent's job.
// Ports:
//   clk, rst     clock, synchronous active-high reset (clears the read register only)
//   we_i         write enable (dropped during reset, for be_i==0 and for addr >= DEPTH)
//   wr_addr_i    write address
//   wdata_i      write data
//   be_i         byte enables
//   re_i         read enable (ignored during reset)
//   rd_addr_i    read address; addr >= DEPTH reads as zero
//   ram_ctrl_i   macro timing trim, used only by the macro build
//   rdata_o      registered read data; holds between reads
module twop_rf_array
  import twop_rf_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] be_i,
  input  logic            re_i,
  input  logic [AW-1:0]   rd_addr_i,
  input  ram_ctrl_t       ram_ctrl_i,
  output logic [DW-1:0]   rdata_o
);

  localparam int        BW      = DW / 8;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic wr_ok;
  logic rd_ok;

  // The extra top bit keeps the compare exact when DEPTH is not a power of two.
  assign wr_ok = we_i && !rst && (be_i != '0) && ({1'b0, wr_addr_i} < DEPTH_W);
  assign rd_ok = {1'b0, rd_addr_i} < DEPTH_W;

`ifdef TWOP_RF_MACRO
  // Vendor macro: active-low enables, active-low bit write mask. Its output
  // latch cannot be reset, so zero_q forces zero after reset or an
  // out-of-range read until the next in-range read.
  logic [DW-1:0] bweb;
  logic [DW-1:0] macro_q;
  logic          zero_d, zero_q;

  always_comb begin
    bweb = '1;
    for (int k = 0; k < BW; k++) begin
      if (be_i[k]) bweb[8*k +: 8] = '0;
    end
  end

  tp_rf_macro #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_macro (
    .clk   (clk),
    .web   (~wr_ok),
    .aa    (wr_addr_i),
    .d     (wdata_i),
    .bweb  (bweb),
    .reb   (~(re_i && !rst && rd_ok)),
    .ab    (rd_addr_i),
    .rtsel (ram_ctrl_i.rtsel),
    .wtsel (ram_ctrl_i.wtsel),
    .mtsel (ram_ctrl_i.mtsel),
    .q     (macro_q)
  );

  always_comb begin
    zero_d = zero_q;
    if (re_i) zero_d = !rd_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) zero_q <= 1'b1;
    else     zero_q <= zero_d;
  end

  assign rdata_o = zero_q ? '0 : macro_q;
`else
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_d, rdata_q;
  logic          unused_ram_ctrl;

  assign unused_ram_ctrl = ^ram_ctrl_i;

  // NOTE: storage has no reset branch on purpose; resetting every word would
  // forbid RAM inference. Only the read register below is cleared.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int k = 0; k < BW; k++) begin
        // NOTE: non-blocking here so the read register sampling on the same
        // edge still sees the old word (read-before-write).
        if (be_i[k]) mem[wr_addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  always_comb begin
    // NOTE: hold value assigned first, so no path leaves rdata_d unassigned (no latch).
    rdata_d = rdata_q;
    if (re_i) rdata_d = rd_ok ? mem[rd_addr_i] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/twop_rf_bypass.sv
// Parametrised two-port register file (1 write, 1 read) with byte-enable
// writes, optional same-cycle read-during-write bypass and an optional output
// register. rvalid_o pulses once for every read, 1+OUT_REG cycles after re_i.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   we_i         write enable
//   wr_addr_i    write address (addr >= DEPTH: write dropped)
//   wdata_i      write data
//   be_i         byte enables, bit k covers wdata_i[8k+7:8k]
//   re_i         read enable
//   rd_addr_i    read address (addr >= DEPTH: reads zero, still valid)
//   ram_ctrl     macro timing trim [1:0] RTSEL, [3:2] WTSEL, [5:4] MTSEL
//   rdata_o      read data; holds between reads, meaningful while rvalid_o=1
//   rvalid_o     one-cycle strobe per completed read
module twop_rf_bypass
  import twop_rf_pkg::*;
#(
  parameter int    DW        = 32,
  parameter int    DEPTH     = 128,
  parameter bit    OUT_REG   = 1'b0,
  parameter bit    BYPASS    = 1'b1,
  parameter string init_file = "",
  localparam int   AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] be_i,
  input  logic            re_i,
  input  logic [AW-1:0]   rd_addr_i,
  input  logic [6:0]      ram_ctrl,
  output logic [DW-1:0]   rdata_o,
  output logic            rvalid_o
);

  localparam int          BW      = DW / 8;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  // Preload images are applied by the FPGA/simulation flow, not by this RTL.
  localparam bit          unused_init = (init_file != "");

  logic [DW-1:0] arr_rdata;

  twop_rf_array #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_array (
    .clk        (clk),
    .rst        (rst),
    .we_i       (we_i),
    .wr_addr_i  (wr_addr_i),
    .wdata_i    (wdata_i),
    .be_i       (be_i),
    .re_i       (re_i),
    .rd_addr_i  (rd_addr_i),
    .ram_ctrl_i (ram_ctrl_t'(ram_ctrl)),
    .rdata_o    (arr_rdata)
  );

  // Stage 1: remember whether this read collided with a same-cycle write and
  // what that write carried; the array itself returns the old word.
  // Registers only move on a read so rdata_o holds between reads.
  logic          hit_d, hit_q;
  logic [DW-1:0] byp_data_d, byp_data_q;
  logic [BW-1:0] byp_be_d, byp_be_q;
  logic          valid1_d, valid1_q;
  logic [DW-1:0] rd1_data;

  always_comb begin
    hit_d      = hit_q;
    byp_data_d = byp_data_q;
    byp_be_d   = byp_be_q;
    valid1_d   = re_i;
    if (re_i) begin
      hit_d      = BYPASS && we_i && (wr_addr_i == rd_addr_i)
                   && ({1'b0, rd_addr_i} < DEPTH_W);
      byp_data_d = wdata_i;
      byp_be_d   = be_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q      <= 1'b0;
      byp_data_q <= '0;
      byp_be_q   <= '0;
      valid1_q   <= 1'b0;
    end else begin
      hit_q      <= hit_d;
      byp_data_q <= byp_data_d;
      byp_be_q   <= byp_be_d;
      valid1_q   <= valid1_d;
    end
  end

  assign rd1_data = hit_q
    ? DW'(be_merge(MAX_DW'(arr_rdata), MAX_DW'(byp_data_q), MAX_BE'(byp_be_q)))
    : arr_rdata;

  generate
    if (OUT_REG) begin : g_out_reg
      logic [DW-1:0] rdata2_d, rdata2_q;
      logic          valid2_d, valid2_q;

      always_comb begin
        rdata2_d = rdata2_q;
        valid2_d = valid1_q;
        if (valid1_q) rdata2_d = rd1_data;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rdata2_q <= '0;
          valid2_q <= 1'b0;
        end else begin
          rdata2_q <= rdata2_d;
          valid2_q <= valid2_d;
        end
      end

      assign rdata_o  = rdata2_q;
      assign rvalid_o = valid2_q;
    end else begin : g_no_out_reg
      assign rdata_o  = rd1_data;
      assign rvalid_o = valid1_q;
    end
  endgenerate

endmodule

// File: tb/tb_twop_rf_bypass.sv
// Bench for twop_rf_bypass. Two instances share one stimulus stream:
//   dut_a: DEPTH=128, OUT_REG=0, BYPASS=1
//   dut_b: DEPTH=100, OUT_REG=1, BYPASS=0 (addresses 100..127 out of range)
// A behavioural model (word arrays plus a per-cycle table of expected read
// results) checks both outputs every cycle.
module tb_twop_rf_bypass;

  localparam int NCYC = 4096;

  logic        clk = 1'b0;
  logic        rst, we, re;
  logic [6:0]  waddr, raddr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [6:0]  ram_ctrl;
  logic [31:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b;

  always #5 clk = ~clk;

  twop_rf_bypass #(.DW(32), .DEPTH(128), .OUT_REG(1'b0), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .we_i(we), .wr_addr_i(waddr), .wdata_i(wdata), .be_i(be),
    .re_i(re), .rd_addr_i(raddr), .ram_ctrl(ram_ctrl), .rdata_o(rdata_a), .rvalid_o(rvalid_a)
  );

  twop_rf_bypass #(.DW(32), .DEPTH(100), .OUT_REG(1'b1), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .we_i(we), .wr_addr_i(waddr), .wdata_i(wdata), .be_i(be),
    .re_i(re), .rd_addr_i(raddr), .ram_ctrl(ram_ctrl), .rdata_o(rdata_b), .rvalid_o(rvalid_b)
  );

  // ---------------- reference model ----------------
  logic [31:0] mm     [2][128];
  bit          ev     [2][NCYC];
  logic [31:0] ed     [2][NCYC];
  logic [31:0] last_m [2];
  int          cyc;
  int          vcnt   [2];
  int          n_checks;
  int          n_errors;

  function automatic int depth_of(int d); return (d == 0) ? 128 : 100; endfunction
  function automatic int lat_of(int d);   return (d == 0) ? 1 : 2;     endfunction
  function automatic bit byp_of(int d);   return d == 0;               endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] b);
    logic [31:0] mask;
    mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs, let the model consume them, then compare both DUTs.
  task automatic step(input logic r, input logic w, input logic [6:0] wa,
                      input logic [31:0] wd, input logic [3:0] b,
                      input logic rr, input logic [6:0] ra);
    int          c;
    int          due;
    logic [31:0] old, res, exp_d, act_d;
    logic        exp_v, act_v;
    rst = r; we = w; waddr = wa; wdata = wd; be = b; re = rr; raddr = ra;
    c = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        for (int i = c; i < NCYC; i++) ev[d][i] = 1'b0;
      end else begin
        if (rr) begin
          old = (int'(ra) < depth_of(d)) ? mm[d][ra] : 32'h0;
          res = (byp_of(d) && w && wa == ra && int'(ra) < depth_of(d)) ? merge(old, wd, b) : old;
          due = c + lat_of(d) - 1;
          if (due < NCYC) begin
            ev[d][due] = 1'b1;
            ed[d][due] = res;
          end
        end
        if (w && int'(wa) < depth_of(d)) mm[d][wa] = merge(mm[d][wa], wd, b);
      end
    end
    @(posedge clk);
    #1;
    cyc = c;
    for (int d = 0; d < 2; d++) begin
      act_v = (d == 0) ? rvalid_a : rvalid_b;
      act_d = (d == 0) ? rdata_a  : rdata_b;
      if (r) begin
        exp_v = 1'b0; exp_d = 32'h0; last_m[d] = 32'h0;
      end else if (ev[d][c]) begin
        exp_v = 1'b1; exp_d = ed[d][c]; last_m[d] = ed[d][c];
      end else begin
        exp_v = 1'b0; exp_d = last_m[d];
      end
      check($sformatf("dut%0d rvalid", d), 32'(act_v), 32'(exp_v));
      check($sformatf("dut%0d rdata", d), act_d, exp_d);
      if (act_v) vcnt[d]++;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 7'd0, 32'h0, 4'h0, 1'b0, 7'd0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        we;
    logic [6:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        re;
    logic [6:0]  ra;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t tbl[10];

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    last_m[0] = 32'h0; last_m[1] = 32'h0;
    vcnt[0] = 0; vcnt[1] = 0;
    ram_ctrl = 7'b0_01_10_11;

    tbl[0] = '{1'b1, 7'd5,   32'hAABBCCDD, 4'hF,    1'b0, 7'd0,   32'h0,        32'h0};
    tbl[1] = '{1'b1, 7'd5,   32'h11223344, 4'b0101, 1'b0, 7'd0,   32'h0,        32'h0};
    tbl[2] = '{1'b0, 7'd0,   32'h0,        4'h0,    1'b1, 7'd5,   32'hAA22CC44, 32'hAA22CC44};
    tbl[3] = '{1'b1, 7'd9,   32'hDEADBEEF, 4'b0011, 1'b1, 7'd9,   32'h0000BEEF, 32'h00000000};
    tbl[4] = '{1'b0, 7'd0,   32'h0,        4'h0,    1'b1, 7'd9,   32'h0000BEEF, 32'h0000BEEF};
    tbl[5] = '{1'b1, 7'd110, 32'hFFFFFFFF, 4'hF,    1'b0, 7'd0,   32'h0,        32'h0};
    tbl[6] = '{1'b0, 7'd0,   32'h0,        4'h0,    1'b1, 7'd110, 32'hFFFFFFFF, 32'h00000000};
    tbl[7] = '{1'b0, 7'd0,   32'h0,        4'h0,    1'b1, 7'd99,  32'h00000000, 32'h00000000};
    tbl[8] = '{1'b1, 7'd5,   32'h00000000, 4'h0,    1'b1, 7'd5,   32'hAA22CC44, 32'hAA22CC44};
    tbl[9] = '{1'b1, 7'd20,  32'h12345678, 4'hF,    1'b1, 7'd21,  32'h00000000, 32'h00000000};

    // Reset held 3 cycles with reads and writes requested: nothing comes out.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 7'd3, 32'h5A5A5A5A, 4'hF, 1'b1, 7'd3);

    // Known contents everywhere (out-of-range writes are dropped by dut_b).
    for (int a = 0; a < 128; a++) step(1'b0, 1'b1, 7'(a), 32'h0, 4'hF, 1'b0, 7'd0);

    // Table: each vector then two idle cycles; dut_a result after 1, dut_b after 2.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be, tbl[i].re, tbl[i].ra);
      if (tbl[i].re) check($sformatf("tbl%0d dut_a", i), rdata_a, tbl[i].exp_a);
      idle();
      if (tbl[i].re) check($sformatf("tbl%0d dut_b", i), rdata_b, tbl[i].exp_b);
      idle();
    end

    // Writes during reset must not reach the array.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 7'd3, 32'h5A5A5A5A, 4'hF, 1'b1, 7'd3);
    step(1'b0, 1'b0, 7'd0, 32'h0, 4'h0, 1'b1, 7'd3);
    check("rst_write dut_a", rdata_a, 32'h0);
    idle();
    check("rst_write dut_b", rdata_b, 32'h0);

    // Write with same-cycle read, then read again next cycle.
    step(1'b0, 1'b1, 7'd30, 32'h0BADF00D, 4'hF, 1'b1, 7'd30);
    step(1'b0, 1'b0, 7'd0, 32'h0, 4'h0, 1'b1, 7'd30);
    check("wr_then_rd dut_a", rdata_a, 32'h0BADF00D);
    idle();
    check("wr_then_rd dut_b", rdata_b, 32'h0BADF00D);
    idle();

    // Random fill, then 128 back-to-back reads.
    for (int a = 0; a < 128; a++)
      step(1'b0, 1'b1, 7'(a), $urandom, 4'($urandom_range(0, 15)), 1'b0, 7'd0);
    vcnt[0] = 0; vcnt[1] = 0;
    for (int a = 0; a < 128; a++) step(1'b0, 1'b0, 7'd0, 32'h0, 4'h0, 1'b1, 7'(a));
    idle();
    idle();
    check("stream count dut_a", 32'(vcnt[0]), 32'd128);
    check("stream count dut_b", 32'(vcnt[1]), 32'd128);

    // Reset one cycle after a read: dut_b's in-flight read is discarded.
    step(1'b0, 1'b0, 7'd0, 32'h0, 4'h0, 1'b1, 7'd5);
    check("midflight dut_a valid", 32'(rvalid_a), 32'd1);
    step(1'b1, 1'b0, 7'd0, 32'h0, 4'h0, 1'b0, 7'd0);
    check("midflight dut_b valid", 32'(rvalid_b), 32'd0);
    idle();
    check("midflight dut_b late", 32'(rvalid_b), 32'd0);
    step(1'b0, 1'b0, 7'd0, 32'h0, 4'h0, 1'b1, 7'd5);
    idle();
    check("resume dut_b valid", 32'(rvalid_b), 32'd1);
    idle();

    // Random traffic including collisions, out-of-range addresses and resets.
    for (int i = 0; i < 500; i++) begin
      logic [6:0] wa, ra;
      wa = 7'($urandom_range(0, 127));
      ra = ($urandom_range(0, 2) == 0) ? wa : 7'($urandom_range(0, 127));
      step(($urandom_range(0, 49) == 0), 1'($urandom), wa, $urandom,
           4'($urandom_range(0, 15)), 1'($urandom), ra);
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
